// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: port identifiers, default
// address/data widths, starvation-counter width and its saturating increment.
package dmem_pkg;

    localparam int DMEM_AW = 14;
    localparam int DMEM_DW = 32;
    localparam int WAIT_W  = 8;

    localparam logic PORT_CPU  = 1'b0;
    localparam logic PORT_HOST = 1'b1;

    // Saturating increment for the host starvation counter (sticks at all-ones).
    function automatic logic [WAIT_W-1:0] wait_sat_inc(input logic [WAIT_W-1:0] v);
        logic [WAIT_W-1:0] res;
        if (v == {WAIT_W{1'b1}}) begin
            res = v;
        end else begin
            res = v + WAIT_W'(1);
        end
        return res;
    endfunction

endpackage : dmem_pkg

// File: rtl/dmem_arb_core.sv
// Winner selection for the shared data RAM plus the last-grant and host
// starvation registers.
// Build option: define ARB_ROUND_ROBIN_EN to alternate winners on contention
// instead of fixed CPU priority with the HOST_MAX_WAIT starvation guard.
module dmem_arb_core
    import dmem_pkg::*;
#(
    parameter int HOST_MAX_WAIT = 8
)
(
    input  logic              clk,
    input  logic              nRst,
    input  logic              i_cpu_req,
    input  logic              i_host_req,
    output logic              o_cpu_win,
    output logic              o_host_win,
    output logic              o_last_gnt,
    output logic [WAIT_W-1:0] o_host_wait
);

`ifndef ARB_ROUND_ROBIN_EN
    localparam logic [WAIT_W-1:0] MAX_WAIT = WAIT_W'(HOST_MAX_WAIT);
`endif

    logic              r_last_gnt;
    logic [WAIT_W-1:0] r_wait;
    logic              w_cpu_win;
    logic              w_host_win;
    logic [WAIT_W-1:0] w_wait_nxt;

`ifdef ARB_ROUND_ROBIN_EN
    // Before the first grant after reset there is no "previous winner", so the
    // CPU takes the first contended slot and alternation starts from there.
    logic r_any_gnt;
`endif

    // Pick at most one winner from the current requests and arbitration state.
    always_comb begin
        w_cpu_win  = 1'b0;
        w_host_win = 1'b0;
        if (i_cpu_req && i_host_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            if (r_any_gnt && (r_last_gnt == PORT_CPU)) begin
                w_host_win = 1'b1;
            end else begin
                w_cpu_win  = 1'b1;
            end
`else
            if (r_wait >= MAX_WAIT) begin
                w_host_win = 1'b1;
            end else begin
                w_cpu_win  = 1'b1;
            end
`endif
        end else if (i_cpu_req) begin
            w_cpu_win = 1'b1;
        end else if (i_host_req) begin
            w_host_win = 1'b1;
        end else begin
            w_cpu_win  = 1'b0;
            w_host_win = 1'b0;
        end
    end

    // Host starvation count: grows while the host asks and loses, else clears.
    always_comb begin
        w_wait_nxt = {WAIT_W{1'b0}};
        if (i_host_req && !w_host_win) begin
            w_wait_nxt = wait_sat_inc(r_wait);
        end else begin
            w_wait_nxt = {WAIT_W{1'b0}};
        end
    end

    // Arbitration state registers: starvation count and most recent winner.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_wait     <= {WAIT_W{1'b0}};
            r_last_gnt <= PORT_CPU;
        end else begin
            r_wait <= w_wait_nxt;
            if (w_cpu_win) begin
                r_last_gnt <= PORT_CPU;
            end else if (w_host_win) begin
                r_last_gnt <= PORT_HOST;
            end else begin
                r_last_gnt <= r_last_gnt;
            end
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Remember whether any grant has happened since reset.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_any_gnt <= 1'b0;
        end else begin
            r_any_gnt <= r_any_gnt | w_cpu_win | w_host_win;
        end
    end
`endif

    assign o_cpu_win   = w_cpu_win;
    assign o_host_win  = w_host_win;
    assign o_last_gnt  = r_last_gnt;
    assign o_host_wait = r_wait;

endmodule : dmem_arb_core

// File: rtl/dmem_arbiter.sv
// Shares one single-port synchronous data RAM between the CPU data port and a
// host/loader port. One access per cycle, grant in the same cycle, read data
// returned one cycle later to the port that issued the read.
// Build option: ARB_ROUND_ROBIN_EN (see dmem_arb_core).
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int AW            = DMEM_AW,
    parameter int DW            = DMEM_DW,
    parameter int HOST_MAX_WAIT = 8
)
(
    input  logic              clk,
    input  logic              nRst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [AW-1:0]     cpu_addr,
    input  logic [DW-1:0]     cpu_wdata,
    output logic              cpu_gnt,
    output logic [DW-1:0]     cpu_rdata,
    output logic              cpu_rvalid,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [AW-1:0]     host_addr,
    input  logic [DW-1:0]     host_wdata,
    output logic              host_gnt,
    output logic [DW-1:0]     host_rdata,
    output logic              host_rvalid,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_wdata,
    output logic              mem_wrEn,
    input  logic [DW-1:0]     mem_rdata,
    output logic [WAIT_W-1:0] host_wait
);

    logic              w_cpu_win;
    logic              w_host_win;
    logic              w_last_gnt;
    logic              w_cpu_gnt;
    logic              w_host_gnt;
    logic              w_sel_we;
    logic [AW-1:0]     w_sel_addr;
    logic [DW-1:0]     w_sel_wdata;
    logic              w_cpu_rvalid;
    logic              w_host_rvalid;
    logic [DW-1:0]     w_cpu_rdata;
    logic [DW-1:0]     w_host_rdata;
    logic [WAIT_W-1:0] w_host_wait;

    logic [AW-1:0]     r_mem_addr;
    logic [DW-1:0]     r_mem_wdata;
    logic              r_rd_pend;
    logic [DW-1:0]     r_cpu_rdata;
    logic [DW-1:0]     r_host_rdata;

    dmem_arb_core #(
        .HOST_MAX_WAIT (HOST_MAX_WAIT)
    ) u_core (
        .clk         (clk),
        .nRst        (nRst),
        .i_cpu_req   (cpu_req),
        .i_host_req  (host_req),
        .o_cpu_win   (w_cpu_win),
        .o_host_win  (w_host_win),
        .o_last_gnt  (w_last_gnt),
        .o_host_wait (w_host_wait)
    );

    // Grants are suppressed while reset is held so nothing reaches the RAM.
    assign w_cpu_gnt  = nRst & w_cpu_win;
    assign w_host_gnt = nRst & w_host_win;

    // Route the winner onto the RAM port; with no grant the address/data hold.
    always_comb begin
        w_sel_we    = 1'b0;
        w_sel_addr  = r_mem_addr;
        w_sel_wdata = r_mem_wdata;
        if (w_cpu_gnt) begin
            w_sel_we    = cpu_we;
            w_sel_addr  = cpu_addr;
            w_sel_wdata = cpu_wdata;
        end else if (w_host_gnt) begin
            w_sel_we    = host_we;
            w_sel_addr  = host_addr;
            w_sel_wdata = host_wdata;
        end else begin
            w_sel_we    = 1'b0;
            w_sel_addr  = r_mem_addr;
            w_sel_wdata = r_mem_wdata;
        end
    end

    // Remember the RAM address/data and whether a read is now in flight.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_mem_addr  <= {AW{1'b0}};
            r_mem_wdata <= {DW{1'b0}};
            r_rd_pend   <= 1'b0;
        end else begin
            r_mem_addr  <= w_sel_addr;
            r_mem_wdata <= w_sel_wdata;
            r_rd_pend   <= (w_cpu_gnt | w_host_gnt) & ~w_sel_we;
        end
    end

    // The read tag is the most recent winner: a pending read was issued by the
    // grant in the previous cycle, which is exactly what last_gnt records.
    assign w_cpu_rvalid  = r_rd_pend & (w_last_gnt == PORT_CPU);
    assign w_host_rvalid = r_rd_pend & (w_last_gnt == PORT_HOST);

    // Pass RAM data to the tagged port; the other port keeps its last data.
    always_comb begin
        w_cpu_rdata  = r_cpu_rdata;
        w_host_rdata = r_host_rdata;
        if (w_cpu_rvalid) begin
            w_cpu_rdata = mem_rdata;
        end else if (w_host_rvalid) begin
            w_host_rdata = mem_rdata;
        end else begin
            w_cpu_rdata  = r_cpu_rdata;
            w_host_rdata = r_host_rdata;
        end
    end

    // Hold the last returned read data per port between returns.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_cpu_rdata  <= {DW{1'b0}};
            r_host_rdata <= {DW{1'b0}};
        end else begin
            r_cpu_rdata  <= w_cpu_rdata;
            r_host_rdata <= w_host_rdata;
        end
    end

    assign cpu_gnt     = w_cpu_gnt;
    assign host_gnt    = w_host_gnt;
    assign mem_addr    = w_sel_addr;
    assign mem_wdata   = w_sel_wdata;
    assign mem_wrEn    = w_sel_we;
    assign cpu_rvalid  = w_cpu_rvalid;
    assign host_rvalid = w_host_rvalid;
    assign cpu_rdata   = w_cpu_rdata;
    assign host_rdata  = w_host_rdata;
    assign host_wait   = w_host_wait;

endmodule : dmem_arbiter

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed reset/CPU/contention/reset-mid-read checks,
// then randomized two-port traffic with a queue-based scoreboard.
module tb_dmem_arbiter;
    import dmem_pkg::*;

    localparam int AW  = 14;
    localparam int DW  = 32;
    localparam int HMW = 8;

    logic          clk = 1'b0;
    logic          nRst;
    logic          cpu_req, cpu_we, host_req, host_we;
    logic [AW-1:0] cpu_addr, host_addr, mem_addr;
    logic [DW-1:0] cpu_wdata, host_wdata, mem_wdata, mem_rdata;
    logic [DW-1:0] cpu_rdata, host_rdata;
    logic          cpu_gnt, host_gnt, cpu_rvalid, host_rvalid, mem_wrEn;
    logic [7:0]    host_wait;

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(AW), .DW(DW), .HOST_MAX_WAIT(HMW)) dut (
        .clk(clk), .nRst(nRst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wrEn(mem_wrEn),
        .mem_rdata(mem_rdata), .host_wait(host_wait)
    );

    // Small synchronous RAM (bench addresses stay below 64).
    logic          ram_clr;
    logic [DW-1:0] ram [0:63];
    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 64; i++) ram[i] <= 32'h0;
            mem_rdata <= 32'h0;
        end else begin
            mem_rdata <= ram[mem_addr[5:0]];
            if (mem_wrEn) ram[mem_addr[5:0]] <= mem_wdata;
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model and scoreboard ----------------
    typedef struct packed { logic act; logic we; logic [13:0] addr; logic [31:0] wdata; } req_t;
    typedef struct packed { logic cg; logic hg; logic wr; logic [13:0] addr; logic [31:0] wdata; logic [7:0] wt; } exp_t;
    typedef struct packed { logic port; logic [31:0] data; int due; } rd_t;

    exp_t          cyc_q[$];
    rd_t           rd_q[$];
    req_t          rq[2];
    logic [31:0]   ref_mem [0:63];
    int            mdl_cnt;
    logic [13:0]   last_addr;
    logic [31:0]   last_wdata;
    int            drv_cyc;
    logic          mon_en;

    // One random cycle: update requesters, drive pins, predict the outcome.
    task automatic step(input int cpu_pct, input int host_pct, input int cancel_pct);
        int   pct[2];
        int   win;
        exp_t e;
        rd_t  r;
        pct[0] = cpu_pct;
        pct[1] = host_pct;
        for (int p = 0; p < 2; p++) begin
            if (rq[p].act && ($urandom_range(0, 99) < cancel_pct)) rq[p].act = 1'b0;
            if (!rq[p].act && ($urandom_range(0, 99) < pct[p])) begin
                rq[p].act   = 1'b1;
                rq[p].we    = 1'($urandom_range(0, 1));
                rq[p].addr  = 14'($urandom_range(0, 31));
                rq[p].wdata = $urandom;
            end
        end
        cpu_req  = rq[0].act; cpu_we  = rq[0].we; cpu_addr  = rq[0].addr; cpu_wdata  = rq[0].wdata;
        host_req = rq[1].act; host_we = rq[1].we; host_addr = rq[1].addr; host_wdata = rq[1].wdata;
        if (!rq[0].act) begin cpu_we = 1'($urandom_range(0, 1)); cpu_addr = 14'($urandom_range(0, 31)); end
        if (!rq[1].act) begin host_we = 1'($urandom_range(0, 1)); host_addr = 14'($urandom_range(0, 31)); end
        if (rq[0].act && rq[1].act) win = (mdl_cnt >= HMW) ? 1 : 0;
        else if (rq[0].act)         win = 0;
        else if (rq[1].act)         win = 1;
        else                        win = -1;
        e.cg = (win == 0);
        e.hg = (win == 1);
        e.wt = 8'(mdl_cnt);
        if (win >= 0) begin
            e.wr = rq[win].we; e.addr = rq[win].addr; e.wdata = rq[win].wdata;
            last_addr = rq[win].addr; last_wdata = rq[win].wdata;
            if (rq[win].we) begin
                ref_mem[rq[win].addr[5:0]] = rq[win].wdata;
            end else begin
                r.port = 1'(win); r.data = ref_mem[rq[win].addr[5:0]]; r.due = drv_cyc + 1;
                rd_q.push_back(r);
            end
            rq[win].act = 1'b0;
        end else begin
            e.wr = 1'b0; e.addr = last_addr; e.wdata = last_wdata;
        end
        if (rq[1].act && win != 1) mdl_cnt = (mdl_cnt >= 255) ? 255 : mdl_cnt + 1;
        else                       mdl_cnt = 0;
        cyc_q.push_back(e);
        drv_cyc++;
    endtask

    // Monitor: compare each cycle's outputs and every read return.
    initial begin
        exp_t        e;
        rd_t         r;
        int          mcyc;
        logic [31:0] hold_c, hold_h;
        mcyc = 0; hold_c = 32'h0; hold_h = 32'h0;
        forever begin
            @(negedge clk);
            if (mon_en && cyc_q.size() > 0) begin
                e = cyc_q.pop_front();
                chk("cpu_gnt", 32'(cpu_gnt), 32'(e.cg));
                chk("host_gnt", 32'(host_gnt), 32'(e.hg));
                chk("mem_wrEn", 32'(mem_wrEn), 32'(e.wr));
                chk("mem_addr", 32'(mem_addr), 32'(e.addr));
                chk("mem_wdata", mem_wdata, e.wdata);
                chk("host_wait", 32'(host_wait), 32'(e.wt));
                if (cpu_rvalid && host_rvalid) begin
                    chk("dual_rvalid", 32'h1, 32'h0);
                end else if (cpu_rvalid || host_rvalid) begin
                    if (rd_q.size() == 0) begin
                        chk("spurious_rvalid", 32'h1, 32'h0);
                    end else begin
                        r = rd_q.pop_front();
                        chk("rvalid_port", 32'(host_rvalid), 32'(r.port));
                        chk("rdata", host_rvalid ? host_rdata : cpu_rdata, r.data);
                        chk("rvalid_cycle", 32'(mcyc), 32'(r.due));
                        if (r.port) hold_h = r.data; else hold_c = r.data;
                    end
                end else if (rd_q.size() > 0 && rd_q[0].due <= mcyc) begin
                    void'(rd_q.pop_front());
                    chk("missing_rvalid", 32'h0, 32'h1);
                end
                if (!cpu_rvalid)  chk("cpu_rdata_hold", cpu_rdata, hold_c);
                if (!host_rvalid) chk("host_rdata_hold", host_rdata, hold_h);
                mcyc++;
            end
        end
    end

    // Stimulus: directed scenarios followed by randomized traffic.
    initial begin
        mon_en = 1'b0; ram_clr = 1'b1; nRst = 1'b0;
        drv_cyc = 0; mdl_cnt = 0; last_addr = 14'h0; last_wdata = 32'h0;
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
        for (int p = 0; p < 2; p++) rq[p] = '0;
        // Reset with both ports requesting writes: everything must stay quiet.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h5; cpu_wdata = 32'h1234_5678;
        host_req = 1'b1; host_we = 1'b1; host_addr = 14'h6; host_wdata = 32'h8765_4321;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cpu_gnt", 32'(cpu_gnt), 32'h0);
        chk("rst_host_gnt", 32'(host_gnt), 32'h0);
        chk("rst_mem_wrEn", 32'(mem_wrEn), 32'h0);
        chk("rst_cpu_rvalid", 32'(cpu_rvalid), 32'h0);
        chk("rst_host_rvalid", 32'(host_rvalid), 32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_cpu_rdata", cpu_rdata, 32'h0);
        chk("rst_host_rdata", host_rdata, 32'h0);
        chk("rst_host_wait", 32'(host_wait), 32'h0);
        @(posedge clk); #1;
        ram_clr = 1'b0; cpu_req = 1'b0; host_req = 1'b0; nRst = 1'b1;

        // CPU only: write then read back.
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h4; cpu_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("wr_cpu_gnt", 32'(cpu_gnt), 32'h1);
        chk("wr_mem_wrEn", 32'(mem_wrEn), 32'h1);
        chk("wr_mem_addr", 32'(mem_addr), 32'h4);
        chk("wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        cpu_we = 1'b0;
        @(negedge clk);
        chk("rd_cpu_gnt", 32'(cpu_gnt), 32'h1);
        chk("rd_mem_wrEn", 32'(mem_wrEn), 32'h0);
        chk("rd_cpu_rvalid_early", 32'(cpu_rvalid), 32'h0);
        @(posedge clk); #1;
        cpu_req = 1'b0;
        @(negedge clk);
        chk("rd_cpu_rvalid", 32'(cpu_rvalid), 32'h1);
        chk("rd_cpu_rdata", cpu_rdata, 32'hDEAD_BEEF);
        chk("rd_host_rvalid", 32'(host_rvalid), 32'h0);
        chk("idle_mem_addr_hold", 32'(mem_addr), 32'h4);
        chk("idle_mem_wrEn", 32'(mem_wrEn), 32'h0);
        ref_mem[4] = 32'hDEAD_BEEF;

        // Contention: host wins once every HMW+1 cycles.
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0;
        host_req = 1'b1; host_we = 1'b0; host_addr = 14'h0;
        for (int i = 0; i < 2 * (HMW + 1); i++) begin
            @(negedge clk);
            chk("cont_cpu_gnt", 32'(cpu_gnt), 32'((i % (HMW + 1)) != HMW));
            chk("cont_host_gnt", 32'(host_gnt), 32'((i % (HMW + 1)) == HMW));
            chk("cont_host_wait", 32'(host_wait), 32'(i % (HMW + 1)));
            @(posedge clk); #1;
        end

        // Reset mid-read: host read granted, reset next cycle drops the return.
        cpu_req = 1'b0; host_req = 1'b1; host_we = 1'b0; host_addr = 14'h10;
        @(negedge clk);
        chk("mid_host_gnt", 32'(host_gnt), 32'h1);
        @(posedge clk); #1;
        nRst = 1'b0; cpu_req = 1'b1; cpu_we = 1'b1;
        @(negedge clk);
        chk("mid_host_rvalid", 32'(host_rvalid), 32'h0);
        chk("mid_host_gnt_rst", 32'(host_gnt), 32'h0);
        chk("mid_cpu_gnt_rst", 32'(cpu_gnt), 32'h0);
        chk("mid_mem_wrEn_rst", 32'(mem_wrEn), 32'h0);
        @(posedge clk); #1;
        nRst = 1'b1; cpu_req = 1'b0; host_req = 1'b0;

        // Randomized traffic against the reference model.
        @(posedge clk); #1;
        mon_en = 1'b1;
        step(90, 50, 4);
        for (int c = 0; c < 300; c++) begin @(posedge clk); #1; step(90, 50, 4); end
        for (int c = 0; c < 300; c++) begin @(posedge clk); #1; step(50, 60, 10); end
        for (int c = 0; c < 3; c++)   begin @(posedge clk); #1; step(0, 0, 100); end
        for (int k = 0; k < 20 && (cyc_q.size() > 0 || rd_q.size() > 0); k++) @(posedge clk);
        if (cyc_q.size() > 0 || rd_q.size() > 0) chk("drain_timeout", 32'(cyc_q.size() + rd_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_dmem_arbiter
